// File: rtl/os_array_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : os_array_ctrl_if
//  Description : Bundle of the job handshake, operand-buffer read port and
//                array-edge drive signals of the output-stationary systolic
//                array sequencer.
//                master : the sequencer (drives busy/done/reads/edges)
//                slave  : host + operand buffers + PE array
//  Signals     : start, cfg_k            job request and reduction length
//                busy, done              job status
//                rd_en, rd_addr          operand buffer read port
//                a_rd_data, b_rd_data    operand vectors (1-cycle latency)
//                a_edge, b_edge          skewed west/north array operands
//                arr_clr_n               active-low clear of all PEs
//  Revision    : 1.0 - initial release
// ============================================================================
interface os_array_ctrl_if #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int KW = 8
) ();
   logic            start;
   logic [KW-1:0]   cfg_k;
   logic            busy;
   logic            done;
   logic            rd_en;
   logic [KW-1:0]   rd_addr;
   logic [N*DW-1:0] a_rd_data;
   logic [N*DW-1:0] b_rd_data;
   logic [N*DW-1:0] a_edge;
   logic [N*DW-1:0] b_edge;
   logic            arr_clr_n;

   modport master (
      input  start, cfg_k, a_rd_data, b_rd_data,
      output busy, done, rd_en, rd_addr, a_edge, b_edge, arr_clr_n
   );

   modport slave (
      output start, cfg_k, a_rd_data, b_rd_data,
      input  busy, done, rd_en, rd_addr, a_edge, b_edge, arr_clr_n
   );
endinterface
`default_nettype wire

// File: rtl/os_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : os_array_ctrl
//  Description : Sequencer for an N x N output-stationary systolic MAC array.
//                On start it clears the PE accumulators, reads K operand
//                vectors from the A/B buffers and drives them onto the west
//                (A) and north (B) array edges with a diagonal skew (lane i
//                delayed by i cycles), waits 2N-1 cycles for the wavefront
//                to drain, then pulses done. Edge lanes carry zero whenever
//                no operand is in flight so results hold between jobs.
//  Ports       : clk          clock, rising edge
//                rst_n        asynchronous reset, ACTIVE-HIGH (1 = reset)
//                bus.master   job handshake, buffer read port, array edges
//  Revision    : 1.0 - initial release
// ============================================================================
module os_array_ctrl #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int KW = 8
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   os_array_ctrl_if.master bus
);

   localparam int                c_flush_w    = $clog2(2 * N);
   localparam logic [c_flush_w-1:0] c_flush_last = c_flush_w'(2 * N - 2);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [KW-1:0]         r_k_len;
   logic [KW-1:0]         r_k;
   logic [c_flush_w-1:0]  r_fl;
   logic [N-1:0]          r_vld;     // bit i: lane i of both edges is valid
   logic                  r_clr_n;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_rd_en;
   wire  [N*DW-1:0]       w_a_edge;
   wire  [N*DW-1:0]       w_b_edge;

   // ------------------------------------------------------------------
   // Next-state and decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_next  = r_state;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      w_rd_en = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            w_busy = 1'b1;
            w_next = (r_k_len != '0) ? S_FEED : S_FLUSH;
         end
         S_FEED: begin
            w_busy  = 1'b1;
            w_rd_en = 1'b1;
            // r_k_len is nonzero here, so the subtraction cannot underflow
            if (r_k == r_k_len - KW'(1)) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            w_busy = 1'b1;
            if (r_fl == c_flush_last) w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State, counters, clear strobe, valid pipeline
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state <= S_IDLE;
         r_k_len <= '0;
         r_k     <= '0;
         r_fl    <= '0;
         r_vld   <= '0;
         r_clr_n <= 1'b0;
      end else begin
         r_state <= w_next;
         // Registered from the next state so the clear is low for exactly
         // the CLEAR cycle and never glitches
         r_clr_n <= (w_next != S_CLEAR);
         if (r_state == S_IDLE && bus.start) r_k_len <= bus.cfg_k;
         r_k     <= (r_state == S_FEED && w_next == S_FEED) ? r_k + KW'(1) : '0;
         r_fl    <= (r_state == S_FLUSH) ? r_fl + c_flush_w'(1) : '0;
         // Buffer data lags rd_en by one cycle; stage i then adds i cycles
         r_vld   <= {r_vld[N-2:0], w_rd_en};
      end
   end

   // ------------------------------------------------------------------
   // Skew network: lane i gets i data registers, gated by its valid bit
   // ------------------------------------------------------------------
   for (genvar i = 0; i < N; i++) begin : g_lane
      if (i == 0) begin : g_direct
         assign w_a_edge[DW-1:0] = r_vld[0] ? bus.a_rd_data[DW-1:0] : '0;
         assign w_b_edge[DW-1:0] = r_vld[0] ? bus.b_rd_data[DW-1:0] : '0;
      end else begin : g_skew
         logic [DW-1:0] r_a_dly [i];
         logic [DW-1:0] r_b_dly [i];

         always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
               for (int m = 0; m < i; m++) begin
                  r_a_dly[m] <= '0;
                  r_b_dly[m] <= '0;
               end
            end else begin
               r_a_dly[0] <= bus.a_rd_data[i*DW +: DW];
               r_b_dly[0] <= bus.b_rd_data[i*DW +: DW];
               for (int m = 1; m < i; m++) begin
                  r_a_dly[m] <= r_a_dly[m-1];
                  r_b_dly[m] <= r_b_dly[m-1];
               end
            end
         end

         assign w_a_edge[i*DW +: DW] = r_vld[i] ? r_a_dly[i-1] : '0;
         assign w_b_edge[i*DW +: DW] = r_vld[i] ? r_b_dly[i-1] : '0;
      end
   end

   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.rd_en     = w_rd_en;
   assign bus.rd_addr   = r_k;
   assign bus.a_edge    = w_a_edge;
   assign bus.b_edge    = w_b_edge;
   assign bus.arr_clr_n = r_clr_n;

endmodule
`default_nettype wire

// File: tb/tb_os_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_os_array_ctrl
//  Description : Directed self-checking bench for os_array_ctrl (N=4).
//                Contains an operand buffer with 1-cycle read latency and a
//                behavioural 4x4 output-stationary MAC array driven by the
//                controller's edges and clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_os_array_ctrl;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int KW = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   os_array_ctrl_if #(.N(N), .DW(DW), .KW(KW)) bus ();

   os_array_ctrl #(.N(N), .DW(DW), .KW(KW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Operand buffers, registered read
   logic [N*DW-1:0] amem [256];
   logic [N*DW-1:0] bmem [256];

   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.a_rd_data <= amem[bus.rd_addr];
         bus.b_rd_data <= bmem[bus.rd_addr];
      end
   end

   // Behavioural output-stationary array: A flows east, B flows south
   logic [31:0]   acc [N][N];
   logic [DW-1:0] pa  [N][N];
   logic [DW-1:0] pb  [N][N];

   always @(posedge clk or negedge bus.arr_clr_n) begin
      if (!bus.arr_clr_n) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               acc[i][j] <= '0;
               pa[i][j]  <= '0;
               pb[i][j]  <= '0;
            end
      end else begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               logic [DW-1:0] ain;
               logic [DW-1:0] bin;
               ain = (j == 0) ? bus.a_edge[i*DW +: DW] : pa[i][j-1];
               bin = (i == 0) ? bus.b_edge[j*DW +: DW] : pb[i-1][j];
               acc[i][j] <= acc[i][j] + 32'(ain) * 32'(bin);
               pa[i][j]  <= ain;
               pb[i][j]  <= bin;
            end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected edge vector at cycle t relative to the first FEED cycle:
   // lane i carries operand k at t = k+1+i, zero otherwise
   function automatic logic [N*DW-1:0] exp_edge(input bit is_a, input int t, input int kk);
      logic [N*DW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         int k;
         k = t - 1 - i;
         if (k >= 0 && k < kk)
            r[i*DW +: DW] = is_a ? amem[k][i*DW +: DW] : bmem[k][i*DW +: DW];
      end
      return r;
   endfunction

   function automatic int exp_acc(input int i, input int j, input int kk);
      int s;
      s = 0;
      for (int k = 0; k < kk; k++)
         s += int'(amem[k][i*DW +: DW]) * int'(bmem[k][j*DW +: DW]);
      return s;
   endfunction

   task automatic chk_edges(input int t, input int kk);
      chk("a_edge", 64'(bus.a_edge), 64'(exp_edge(1'b1, t, kk)));
      chk("b_edge", 64'(bus.b_edge), 64'(exp_edge(1'b0, t, kk)));
   endtask

   // Issues start from IDLE and checks every cycle up to the IDLE after done
   task automatic run_job(input int kk, input bit hold);
      bus.cfg_k = KW'(kk);
      bus.start = 1'b1;
      tick();                               // CLEAR
      if (!hold) bus.start = 1'b0;
      bus.cfg_k = '0;                       // K must already be latched
      chk("clear_busy",  64'(bus.busy),      64'(1));
      chk("clear_clr_n", 64'(bus.arr_clr_n), 64'(0));
      chk("clear_rd_en", 64'(bus.rd_en),     64'(0));
      chk_edges(-1, kk);
      for (int t = 0; t < kk + 2*N - 1; t++) begin
         tick();                            // FEED then FLUSH
         chk("rd_en", 64'(bus.rd_en), 64'(t < kk));
         if (t < kk) chk("rd_addr", 64'(bus.rd_addr), 64'(t));
         chk("busy",      64'(bus.busy),      64'(1));
         chk("done_early",64'(bus.done),      64'(0));
         chk("clr_n",     64'(bus.arr_clr_n), 64'(1));
         chk_edges(t, kk);
      end
      tick();                               // DONE
      chk("done",      64'(bus.done),  64'(1));
      chk("done_busy", 64'(bus.busy),  64'(0));
      chk("done_rd_en",64'(bus.rd_en), 64'(0));
      chk_edges(kk + 2*N - 1, kk);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            chk("pe_acc", 64'(acc[i][j]), 64'(exp_acc(i, j, kk)));
      tick();                               // IDLE, never straight to CLEAR
      chk("idle_done",  64'(bus.done),      64'(0));
      chk("idle_busy",  64'(bus.busy),      64'(0));
      chk("idle_clr_n", 64'(bus.arr_clr_n), 64'(1));
      chk_edges(kk + 2*N, kk);
   endtask

   initial begin
      bit seen_done;
      bus.start = 1'b0;
      bus.cfg_k = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",  64'(bus.busy),      64'(0));
      chk("rst_done",  64'(bus.done),      64'(0));
      chk("rst_rd_en", 64'(bus.rd_en),     64'(0));
      chk("rst_addr",  64'(bus.rd_addr),   64'(0));
      chk("rst_a",     64'(bus.a_edge),    64'(0));
      chk("rst_b",     64'(bus.b_edge),    64'(0));
      chk("rst_clr_n", 64'(bus.arr_clr_n), 64'(0));
      rst_n = 1'b0;
      tick();
      chk("rel_clr_n", 64'(bus.arr_clr_n), 64'(1));
      chk("rel_busy",  64'(bus.busy),      64'(0));
      // Mid-clock assertion takes effect without a clock edge
      #3 rst_n = 1'b1;
      #1;
      chk("async_clr_n", 64'(bus.arr_clr_n), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b0;
      tick();
      chk("rel2_clr_n", 64'(bus.arr_clr_n), 64'(1));

      // K=3, A all ones, B all twos -> every PE = 6
      for (int k = 0; k < 3; k++) begin
         amem[k] = 32'h01010101;
         bmem[k] = 32'h02020202;
      end
      run_job(3, 1'b0);
      chk("pe_six", 64'(acc[N-1][N-1]), 64'(6));

      // K=1, distinct lanes: checks each lane's skew individually
      amem[0] = 32'h04030201;
      bmem[0] = 32'h08070605;
      tick();
      run_job(1, 1'b0);

      // K=0: no reads, all PEs zero
      tick();
      run_job(0, 1'b0);
      chk("k0_pe", 64'(acc[0][0]), 64'(0));

      // start held through the job and DONE; second job from IDLE only
      amem[0] = 32'h03030303; amem[1] = 32'h01020304;
      bmem[0] = 32'h02020202; bmem[1] = 32'h05050505;
      tick();
      run_job(2, 1'b1);
      amem[0] = 32'h01000100; amem[1] = 32'h00020002;
      bmem[0] = 32'h03030303; bmem[1] = 32'h01000001;
      run_job(2, 1'b0);

      // Reset during FEED at k=1
      tick();
      bus.cfg_k = KW'(3);
      bus.start = 1'b1;
      tick();                               // CLEAR
      bus.start = 1'b0;
      tick();                               // FEED k=0
      tick();                               // FEED k=1
      chk("abort_rd_en_pre", 64'(bus.rd_en),   64'(1));
      chk("abort_addr_pre",  64'(bus.rd_addr), 64'(1));
      #2 rst_n = 1'b1;
      #1;
      chk("abort_rd_en", 64'(bus.rd_en),     64'(0));
      chk("abort_busy",  64'(bus.busy),      64'(0));
      chk("abort_clr_n", 64'(bus.arr_clr_n), 64'(0));
      chk("abort_a",     64'(bus.a_edge),    64'(0));
      chk("abort_b",     64'(bus.b_edge),    64'(0));
      @(posedge clk);
      #1 rst_n = 1'b0;
      seen_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.done) seen_done = 1'b1;
      end
      chk("abort_no_done", 64'(seen_done), 64'(0));

      amem[0] = 32'h0a0b0c0d; amem[1] = 32'h01010101;
      bmem[0] = 32'h01020304; bmem[1] = 32'h10101010;
      run_job(2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
